// File: rtl/mem_port_arbiter.sv
// Shares one byte-write memory port between instruction fetch and load/store.
// Reads are single word reads; stores are split into big-endian byte writes.
module mem_port_arbiter #(
   parameter int unsigned MEM_BYTES   = 1024,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic        IReq,
   input  logic [31:0] IAddr,
   output logic        IAck,
   output logic [31:0] IData,
   input  logic        DReq,
   input  logic        DWe,
   input  logic [1:0]  DSize,
   input  logic [31:0] DAddr,
   input  logic [31:0] DWData,
   output logic        DAck,
   output logic [31:0] DRData,
   output logic        DErr,
   output logic [31:0] MemAddress,
   output logic [31:0] MemWriteData,
   output logic        MemRead,
   output logic        MemWrite,
   input  logic [31:0] MemData
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
   typedef enum logic {FETCH, DATA} req_t;

   state_t      state;
   req_t        last_grant;
   req_t        owner;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [2:0]  nbytes_q;
   logic [1:0]  byte_cnt;
   logic [3:0]  wait_cnt;

   logic        grant_valid;
   logic        grant_data;
   logic        grant_we;
   logic [31:0] grant_addr;
   logic [2:0]  grant_nbytes;
   logic [32:0] grant_end;
   logic        grant_err;
   logic        last_byte;

   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         2'b00:   size_bytes = 3'd1;
         2'b01:   size_bytes = 3'd2;
         default: size_bytes = 3'd4;
      endcase
   endfunction

   // Byte k of an n-byte store; the most significant byte goes out first.
   function automatic logic [7:0] store_byte(input logic [31:0] data,
                                             input logic [2:0]  n,
                                             input logic [1:0]  k);
      logic [1:0] idx;
      idx = 2'(n - 3'd1 - {1'b0, k});
      case (idx)
         2'd0:    store_byte = data[7:0];
         2'd1:    store_byte = data[15:8];
         2'd2:    store_byte = data[23:16];
         default: store_byte = data[31:24];
      endcase
   endfunction

   always_comb begin
      grant_valid  = IReq | DReq;
      grant_data   = DReq & (~IReq | (last_grant == FETCH));
      grant_we     = grant_data & DWe;
      grant_addr   = grant_data ? DAddr : IAddr;
      grant_nbytes = grant_data ? size_bytes(DSize) : 3'd4;
      grant_end    = {1'b0, grant_addr} + 33'(grant_nbytes) - 33'd1;
      grant_err    = (grant_end >= 33'(MEM_BYTES));
      last_byte    = ({1'b0, byte_cnt} == (nbytes_q - 3'd1));
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state        <= IDLE;
         last_grant   <= FETCH;
         owner        <= FETCH;
         addr_q       <= '0;
         wdata_q      <= '0;
         nbytes_q     <= '0;
         byte_cnt     <= '0;
         wait_cnt     <= '0;
         IAck         <= 1'b0;
         IData        <= '0;
         DAck         <= 1'b0;
         DRData       <= '0;
         DErr         <= 1'b0;
         MemAddress   <= '0;
         MemWriteData <= '0;
         MemRead      <= 1'b0;
         MemWrite     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               IAck <= 1'b0;
               DAck <= 1'b0;
               DErr <= 1'b0;
               if (grant_valid) begin
                  owner      <= grant_data ? DATA : FETCH;
                  last_grant <= grant_data ? DATA : FETCH;
                  addr_q     <= grant_addr;
                  wdata_q    <= DWData;
                  nbytes_q   <= grant_nbytes;
                  byte_cnt   <= '0;
                  wait_cnt   <= '0;
                  if (grant_err) begin
                     state <= DONE;
                     if (grant_data) begin
                        DAck   <= 1'b1;
                        DErr   <= 1'b1;
                        DRData <= '0;
                     end else begin
                        IAck  <= 1'b1;
                        IData <= '0;
                     end
                  end else if (grant_we) begin
                     state        <= WR;
                     MemWrite     <= 1'b1;
                     MemAddress   <= grant_addr;
                     MemWriteData <= {24'b0, store_byte(DWData, grant_nbytes, 2'd0)};
                  end else begin
                     state      <= RD;
                     MemRead    <= 1'b1;
                     MemAddress <= grant_addr;
                  end
               end
            end

            RD: begin
               if (wait_cnt == 4'(WAIT_STATES)) begin
                  state      <= DONE;
                  MemRead    <= 1'b0;
                  MemAddress <= '0;
                  if (owner == DATA) begin
                     DRData <= MemData;
                     DAck   <= 1'b1;
                  end else begin
                     IData <= MemData;
                     IAck  <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end

            WR: begin
               if (last_byte) begin
                  state        <= DONE;
                  MemWrite     <= 1'b0;
                  MemAddress   <= '0;
                  MemWriteData <= '0;
                  DAck         <= 1'b1;
               end else begin
                  byte_cnt     <= byte_cnt + 2'd1;
                  MemAddress   <= addr_q + 32'(byte_cnt) + 32'd1;
                  MemWriteData <= {24'b0, store_byte(wdata_q, nbytes_q, byte_cnt + 2'd1)};
               end
            end

            default: begin
               state <= IDLE;
               IAck  <= 1'b0;
               DAck  <= 1'b0;
               DErr  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-array memory model behind the port.
module tb_mem_port_arbiter;

   logic        Clock = 1'b0;
   logic        Reset_n;
   logic        IReq, DReq, DWe;
   logic [31:0] IAddr, DAddr, DWData;
   logic [1:0]  DSize;
   logic        IAck, DAck, DErr, MemRead, MemWrite;
   logic [31:0] IData, DRData, MemAddress, MemWriteData, MemData;

   logic [7:0]  mem [0:1023];
   logic [39:0] wr_log [$];
   int          rd_cycles = 0;
   int          both_strobe = 0;
   int          both_ack = 0;

   int          n_checks = 0;
   int          n_fail = 0;
   int          lat, n_reads, n_writes, rd_base, wr_base, ack_cnt;
   logic        err_seen;
   logic [3:0]  order;
   int          stamp [4];
   int          cyc, w;

   mem_port_arbiter #(.MEM_BYTES(1024), .WAIT_STATES(2)) dut (
      .Clock(Clock), .Reset_n(Reset_n),
      .IReq(IReq), .IAddr(IAddr), .IAck(IAck), .IData(IData),
      .DReq(DReq), .DWe(DWe), .DSize(DSize), .DAddr(DAddr), .DWData(DWData),
      .DAck(DAck), .DRData(DRData), .DErr(DErr),
      .MemAddress(MemAddress), .MemWriteData(MemWriteData),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemData(MemData)
   );

   always #5 Clock = ~Clock;

   // Memory model: byte i starts as i[7:0]; writes land on the rising edge.
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
      forever begin
         @(posedge Clock);
         if (MemWrite && MemAddress < 32'd1024) mem[MemAddress[9:0]] = MemWriteData[7:0];
      end
   end

   always_comb begin
      MemData = '0;
      if (MemAddress <= 32'd1020)
         MemData = {mem[MemAddress[9:0]], mem[MemAddress[9:0] + 10'd1],
                    mem[MemAddress[9:0] + 10'd2], mem[MemAddress[9:0] + 10'd3]};
   end

   always @(negedge Clock) begin
      if (MemWrite) wr_log.push_back({MemAddress, MemWriteData[7:0]});
      if (MemRead) rd_cycles++;
      if (MemRead && MemWrite) both_strobe++;
      if (IAck && DAck) both_ack++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic data_xfer(input logic we, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wd);
      @(negedge Clock);
      rd_base = rd_cycles;
      wr_base = wr_log.size();
      DReq = 1'b1; DWe = we; DSize = size; DAddr = addr; DWData = wd;
      lat = 0;
      do begin @(negedge Clock); lat++; end while (!DAck && lat < 40);
      err_seen = DErr;
      DReq = 1'b0;
      #1;
      n_reads  = rd_cycles - rd_base;
      n_writes = wr_log.size() - wr_base;
   endtask

   task automatic fetch_xfer(input logic [31:0] addr);
      @(negedge Clock);
      rd_base = rd_cycles;
      wr_base = wr_log.size();
      IReq = 1'b1; IAddr = addr;
      lat = 0;
      do begin @(negedge Clock); lat++; end while (!IAck && lat < 40);
      IReq = 1'b0;
      #1;
      n_reads  = rd_cycles - rd_base;
      n_writes = wr_log.size() - wr_base;
   endtask

   // Expected bytes are listed left-justified in issue order.
   task automatic check_writes(input string tag, input logic [31:0] a0,
                               input logic [31:0] bytes_exp, input int n);
      logic [39:0] e;
      check({tag, "_count"}, 32'(n_writes), 32'(n));
      for (int k = 0; k < n && k < n_writes; k++) begin
         e = wr_log[wr_base + k];
         check($sformatf("%s_addr%0d", tag, k), e[39:8], a0 + 32'(k));
         check($sformatf("%s_byte%0d", tag, k), 32'(e[7:0]), 32'(bytes_exp[31 - 8*k -: 8]));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      Reset_n = 1'b0;
      IReq = 1'b0; DReq = 1'b0; DWe = 1'b0; DSize = 2'b00;
      IAddr = '0; DAddr = '0; DWData = '0;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      check("rst_ack", 32'({IAck, DAck, DErr}), 32'd0);
      check("rst_strobe", 32'({MemRead, MemWrite}), 32'd0);
      check("rst_addr", MemAddress, 32'd0);
      check("rst_wdata", MemWriteData, 32'd0);
      check("rst_idata", IData, 32'd0);
      check("rst_drdata", DRData, 32'd0);
      Reset_n = 1'b1;

      // Both requesters held high from reset: data wins the first tie.
      @(negedge Clock);
      IReq = 1'b1; DReq = 1'b1; DWe = 1'b0; DSize = 2'b10; DAddr = 32'h8; IAddr = 32'h10;
      cyc = 0;
      for (int i = 0; i < 4; i++) begin
         w = 0;
         do begin @(negedge Clock); cyc++; w++; end while (!(IAck || DAck) && w < 40);
         order[3 - i] = DAck;
         stamp[i] = cyc;
      end
      IReq = 1'b0; DReq = 1'b0;
      check("rr_order", 32'(order), 32'b1010);
      check("rr_first_ack", 32'(stamp[0]), 32'd4);
      check("rr_gap1", 32'(stamp[1] - stamp[0]), 32'd5);
      check("rr_gap3", 32'(stamp[3] - stamp[2]), 32'd5);
      check("rr_idata", IData, 32'h10111213);
      check("rr_drdata", DRData, 32'h08090A0B);

      data_xfer(1'b1, 2'b10, 32'h20, 32'hA1B2C3D4);
      check("sw_lat", 32'(lat), 32'd5);
      check("sw_err", 32'(err_seen), 32'd0);
      check("sw_reads", 32'(n_reads), 32'd0);
      check_writes("sw", 32'h20, 32'hA1B2C3D4, 4);

      fetch_xfer(32'h20);
      check("f20_lat", 32'(lat), 32'd4);
      check("f20_reads", 32'(n_reads), 32'd3);
      check("f20_data", IData, 32'hA1B2C3D4);

      data_xfer(1'b1, 2'b01, 32'h30, 32'h0000BEEF);
      check("sh_lat", 32'(lat), 32'd3);
      check_writes("sh", 32'h30, 32'hBEEF0000, 2);

      data_xfer(1'b1, 2'b00, 32'h33, 32'h00000055);
      check("sb_lat", 32'(lat), 32'd2);
      check_writes("sb", 32'h33, 32'h55000000, 1);

      fetch_xfer(32'h4);
      check("f4_lat", 32'(lat), 32'd4);
      check("f4_reads", 32'(n_reads), 32'd3);
      check("f4_data", IData, 32'h04050607);

      fetch_xfer(32'h30);
      check("f30_data", IData, 32'hBEEF3255);

      data_xfer(1'b0, 2'b00, 32'h21, 32'h0);
      check("lb_lat", 32'(lat), 32'd4);
      check("lb_data", DRData, 32'hB2C3D424);

      data_xfer(1'b0, 2'b10, 32'd1022, 32'h0);
      check("lw_oor_lat", 32'(lat), 32'd1);
      check("lw_oor_err", 32'(err_seen), 32'd1);
      check("lw_oor_reads", 32'(n_reads), 32'd0);
      check("lw_oor_data", DRData, 32'd0);

      data_xfer(1'b1, 2'b10, 32'd1020, 32'hCAFEF00D);
      check("sw_top_lat", 32'(lat), 32'd5);
      check("sw_top_err", 32'(err_seen), 32'd0);
      check_writes("sw_top", 32'd1020, 32'hCAFEF00D, 4);

      fetch_xfer(32'd1020);
      check("f_top_data", IData, 32'hCAFEF00D);

      data_xfer(1'b1, 2'b01, 32'd1023, 32'h00001234);
      check("sh_oor_lat", 32'(lat), 32'd1);
      check("sh_oor_err", 32'(err_seen), 32'd1);
      check("sh_oor_writes", 32'(n_writes), 32'd0);

      fetch_xfer(32'd1021);
      check("f_oor_lat", 32'(lat), 32'd1);
      check("f_oor_reads", 32'(n_reads), 32'd0);
      check("f_oor_data", IData, 32'd0);

      // Store abandoned by reset after its second byte has been written.
      @(negedge Clock);
      wr_base = wr_log.size();
      DReq = 1'b1; DWe = 1'b1; DSize = 2'b10; DAddr = 32'h40; DWData = 32'h11223344;
      w = 0;
      do begin @(negedge Clock); #1; w++; end while (wr_log.size() - wr_base < 2 && w < 40);
      check("mid_two_writes", 32'(wr_log.size() - wr_base), 32'd2);
      @(posedge Clock);
      #1;
      Reset_n = 1'b0;
      DReq = 1'b0;
      #1;
      check("mid_strobe", 32'({MemRead, MemWrite}), 32'd0);
      check("mid_addr", MemAddress, 32'd0);
      check("mid_wdata", MemWriteData, 32'd0);
      ack_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clock);
         if (DAck || IAck) ack_cnt++;
         if (i == 2) Reset_n = 1'b1;
      end
      check("mid_no_ack", 32'(ack_cnt), 32'd0);
      fetch_xfer(32'h40);
      check("mid_mem", IData, 32'h11224243);

      check("never_both_strobes", 32'(both_strobe), 32'd0);
      check("never_both_acks", 32'(both_ack), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
